// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arithmetic ops plus iterative shift-add
// multiply and restoring divide, one bit per clock, with a start/busy/done handshake.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] alu0,
  input  logic [WIDTH-1:0] alu1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] aluout,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_LSF = 5'd2;
  localparam logic [4:0] OP_RSF = 5'd3;
  localparam logic [4:0] OP_AND = 5'd4;
  localparam logic [4:0] OP_OR  = 5'd5;
  localparam logic [4:0] OP_XOR = 5'd6;
  localparam logic [4:0] OP_LHI = 5'd7;
  localparam logic [4:0] OP_MUL = 5'd10;
  localparam logic [4:0] OP_DIV = 5'd11;
  localparam logic [4:0] OP_REM = 5'd12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [4:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] aluout_q, aluout_d;
  logic             dz_q, dz_d;

  logic             accept_s;
  logic             div_op_s;
  logic             b_zero_s;
  logic             multi_s;
  logic             last_iter_s;
  logic [WIDTH-1:0] single_res_s;
  logic [WIDTH-1:0] mul_acc_s;
  logic [WIDTH:0]   shl_rem_s;
  logic [WIDTH:0]   trial_s;
  logic             div_ok_s;
  logic [WIDTH-1:0] rem_next_s;
  logic [WIDTH-1:0] quo_next_s;

  // Results for every opcode that completes on the accepting edge; DIV/REM only
  // reach this path with a zero divisor.
  function automatic logic [WIDTH-1:0] single_result(
    input logic [4:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
    case (op)
      OP_ADD:  single_result = a + b;
      OP_SUB:  single_result = a - b;
      OP_LSF:  single_result = a << sh;
      OP_RSF:  single_result = $unsigned($signed(a) >>> sh);
      OP_AND:  single_result = a & b;
      OP_OR:   single_result = a | b;
      OP_XOR:  single_result = a ^ b;
      OP_LHI:  single_result = {b[WIDTH/2-1:0], a[WIDTH/2-1:0]};
      OP_DIV:  single_result = {WIDTH{1'b1}};
      OP_REM:  single_result = a;
      default: single_result = {WIDTH{1'b0}};
    endcase
  endfunction

  // Request decode: acceptance, zero-divisor detection and single-cycle result
  always_comb begin
    accept_s     = start && (state_q != S_CALC);
    div_op_s     = (opcode == OP_DIV) || (opcode == OP_REM);
    b_zero_s     = (alu1 == {WIDTH{1'b0}});
    multi_s      = (opcode == OP_MUL) || (div_op_s && !b_zero_s);
    single_res_s = single_result(opcode, alu0, alu1);
    last_iter_s  = (state_q == S_CALC) && (cnt_q == CW'(1));
  end

  // One iteration of shift-add multiply and of restoring divide
  always_comb begin
    mul_acc_s  = a_q[0] ? (acc_q + b_q) : acc_q;
    shl_rem_s  = {acc_q, a_q[WIDTH-1]};
    trial_s    = shl_rem_s - {1'b0, b_q};
    div_ok_s   = ~trial_s[WIDTH];
    rem_next_s = div_ok_s ? trial_s[WIDTH-1:0] : shl_rem_s[WIDTH-1:0];
    quo_next_s = {a_q[WIDTH-2:0], div_ok_s};
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_s) begin
          state_d = multi_s ? S_CALC : S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (last_iter_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_CALC;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; busy/done follow the state register directly
  always_comb begin
    busy   = (state_q == S_CALC);
    done   = (state_q == S_DONE);
    aluout = aluout_q;
    dz     = dz_q;
  end

  // Datapath next-state: operands are latched on accept so later input
  // changes cannot disturb an operation in flight.
  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    aluout_d = aluout_q;
    dz_d     = dz_q;
    if (accept_s) begin
      op_d = opcode;
      if (multi_s) begin
        cnt_d = CW'(WIDTH);
        a_d   = alu0;
        b_d   = alu1;
        acc_d = {WIDTH{1'b0}};
      end else begin
        cnt_d    = {CW{1'b0}};
        aluout_d = single_res_s;
        dz_d     = div_op_s && b_zero_s;
      end
    end else if (state_q == S_CALC) begin
      cnt_d = cnt_q - CW'(1);
      if (op_q == OP_MUL) begin
        acc_d = mul_acc_s;
        a_d   = a_q >> 1;
        b_d   = b_q << 1;
      end else begin
        acc_d = rem_next_s;
        a_d   = quo_next_s;
      end
      if (last_iter_s) begin
        dz_d = 1'b0;
        if (op_q == OP_MUL) begin
          aluout_d = mul_acc_s;
        end else if (op_q == OP_DIV) begin
          aluout_d = quo_next_s;
        end else begin
          aluout_d = rem_next_s;
        end
      end else begin
        dz_d = dz_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= {CW{1'b0}};
      op_q     <= 5'd0;
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      aluout_q <= {WIDTH{1'b0}};
      dz_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      aluout_q <= aluout_d;
      dz_q     <= dz_d;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: a 32-bit and a 16-bit instance run in lockstep,
// expected results are queued when a request is driven and popped on done.
module tb_seq_alu;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_LSF = 5'd2;
  localparam logic [4:0] OP_RSF = 5'd3;
  localparam logic [4:0] OP_AND = 5'd4;
  localparam logic [4:0] OP_OR  = 5'd5;
  localparam logic [4:0] OP_XOR = 5'd6;
  localparam logic [4:0] OP_LHI = 5'd7;
  localparam logic [4:0] OP_MUL = 5'd10;
  localparam logic [4:0] OP_DIV = 5'd11;
  localparam logic [4:0] OP_REM = 5'd12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  opcode = 5'd0;
  logic [31:0] alu0 = 32'd0;
  logic [31:0] alu1 = 32'd0;

  logic        busy32, done32, dz32;
  logic [31:0] out32;
  logic        busy16, done16, dz16;
  logic [15:0] out16;

  seq_alu #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .alu0(alu0), .alu1(alu1),
    .busy(busy32), .done(done32), .aluout(out32), .dz(dz32)
  );

  seq_alu #(.WIDTH(16)) u_dut16 (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .alu0(alu0[15:0]), .alu1(alu1[15:0]),
    .busy(busy16), .done(done16), .aluout(out16), .dz(dz16)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        dz;
    int          due;
  } exp_t;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        dz;
  } vec_t;

  exp_t        q0[$];
  exp_t        q1[$];
  vec_t        vt[22];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  bit          chk_en = 1'b0;
  logic [31:0] last_res[2];
  logic        last_dz[2];
  int          bs[2];
  int          be[2];

  // Reference model written from the operation definitions, masked to width w.
  function automatic void model(input int w, input logic [4:0] op,
                                input logic [31:0] a_in, input logic [31:0] b_in,
                                output logic [31:0] res, output logic dz);
    logic [31:0] m, hm, a, b;
    logic [63:0] p;
    int s;
    m  = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    hm = (w == 32) ? 32'h0000_FFFF : 32'h0000_00FF;
    a  = a_in & m;
    b  = b_in & m;
    s  = (w == 32) ? int'(b[4:0]) : int'(b[3:0]);
    dz = 1'b0;
    res = 32'd0;
    case (op)
      OP_ADD: res = (a + b) & m;
      OP_SUB: res = (a - b) & m;
      OP_LSF: res = (a << s) & m;
      OP_RSF: begin
        res = a >> s;
        if (a[w-1]) res = res | (m & ~(m >> s));
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_LHI: res = ((b & hm) << (w / 2)) | (a & hm);
      OP_MUL: begin
        p = {32'd0, a} * {32'd0, b};
        res = p[31:0] & m;
      end
      OP_DIV: if (b == 32'd0) begin res = m; dz = 1'b1; end else res = a / b;
      OP_REM: if (b == 32'd0) begin res = a; dz = 1'b1; end else res = a % b;
      default: res = 32'd0;
    endcase
  endfunction

  function automatic bit is_multi(input int w, input logic [4:0] op, input logic [31:0] b);
    logic [31:0] m;
    m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    return (op == OP_MUL) || (((op == OP_DIV) || (op == OP_REM)) && ((b & m) != 32'd0));
  endfunction

  task automatic check_one(input int k, input logic [31:0] out, input logic dzv,
                           input logic busyv, input logic donev);
    exp_t e;
    bit   exp_done;
    bit   exp_busy;
    int   w;
    w = (k == 0) ? 32 : 16;
    exp_busy = (cyc >= bs[k]) && (cyc <= be[k]);
    n_chk++;
    if (busyv !== exp_busy) begin
      n_fail++;
      $display("FAIL busy w%0d cyc %0d: got %b expected %b", w, cyc, busyv, exp_busy);
    end
    exp_done = 1'b0;
    if (k == 0) begin
      if (q0.size() > 0 && q0[0].due == cyc) begin exp_done = 1'b1; e = q0.pop_front(); end
    end else begin
      if (q1.size() > 0 && q1[0].due == cyc) begin exp_done = 1'b1; e = q1.pop_front(); end
    end
    n_chk++;
    if (donev !== exp_done) begin
      n_fail++;
      $display("FAIL done w%0d cyc %0d: got %b expected %b", w, cyc, donev, exp_done);
    end
    if (exp_done) begin
      last_res[k] = e.res;
      last_dz[k]  = e.dz;
    end
    n_chk++;
    if (out !== last_res[k] || dzv !== last_dz[k]) begin
      n_fail++;
      $display("FAIL result w%0d cyc %0d: got %h dz %b expected %h dz %b",
               w, cyc, out, dzv, last_res[k], last_dz[k]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    if (chk_en) begin
      check_one(0, out32, dz32, busy32, done32);
      check_one(1, {16'd0, out16}, dz16, busy16, done16);
    end
  endtask

  task automatic push(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] r32, input logic d32);
    exp_t e;
    logic [31:0] r;
    logic d;
    e.res = r32;
    e.dz  = d32;
    e.due = cyc + 1 + (is_multi(32, op, b) ? 32 : 0);
    q0.push_back(e);
    if (is_multi(32, op, b)) begin bs[0] = cyc + 1; be[0] = cyc + 32; end
    model(16, op, a, b, r, d);
    e.res = r;
    e.dz  = d;
    e.due = cyc + 1 + (is_multi(16, op, b) ? 16 : 0);
    q1.push_back(e);
    if (is_multi(16, op, b)) begin bs[1] = cyc + 1; be[1] = cyc + 16; end
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r32, input logic d32);
    push(op, a, b, r32, d32);
    start  = 1'b1;
    opcode = op;
    alu0   = a;
    alu1   = b;
    tick();
    start  = 1'b0;
    opcode = 5'($urandom);
    alu0   = $urandom;
    alu1   = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
      tick();
      n++;
    end
    n_chk++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL timeout: %0d/%0d results outstanding, expected 0", q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
  endtask

  task automatic run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] r32, input logic d32);
    issue(op, a, b, r32, d32);
    drain();
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0};
    vt[1]  = '{OP_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0};
    vt[2]  = '{OP_SUB, 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0};
    vt[3]  = '{OP_LSF, 32'h0000_00F1, 32'h0000_0024, 32'h0000_0F10, 1'b0};
    vt[4]  = '{OP_RSF, 32'h8000_0000, 32'h0000_0104, 32'hF800_0000, 1'b0};
    vt[5]  = '{OP_RSF, 32'h7FFF_FFFF, 32'h0000_001F, 32'h0000_0000, 1'b0};
    vt[6]  = '{OP_LHI, 32'h0000_1234, 32'h0000_ABCD, 32'hABCD_1234, 1'b0};
    vt[7]  = '{OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0};
    vt[8]  = '{OP_OR,  32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0};
    vt[9]  = '{OP_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0};
    vt[10] = '{5'd8,   32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 1'b0};
    vt[11] = '{5'd31,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vt[12] = '{OP_MUL, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 1'b0};
    vt[13] = '{OP_MUL, 32'h1234_5678, 32'h0000_0009, 32'hA3D7_0A38, 1'b0};
    vt[14] = '{OP_DIV, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0};
    vt[15] = '{OP_REM, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 1'b0};
    vt[16] = '{OP_DIV, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};
    vt[17] = '{OP_REM, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1'b1};
    vt[18] = '{OP_DIV, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0};
    vt[19] = '{OP_REM, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 1'b0};
    vt[20] = '{OP_DIV, 32'h0000_0007, 32'h0000_0064, 32'h0000_0000, 1'b0};
    vt[21] = '{OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};

    for (int k = 0; k < 2; k++) begin
      last_res[k] = 32'd0;
      last_dz[k]  = 1'b0;
      bs[k] = 1;
      be[k] = 0;
    end

    reset = 1'b1;
    tick();
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      run(vt[i].op, vt[i].a, vt[i].b, vt[i].res, vt[i].dz);
    end

    // start pulsed while multiplying must be ignored
    issue(OP_MUL, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 1'b0);
    repeat (4) tick();
    start = 1'b1; opcode = OP_ADD; alu0 = 32'd1; alu1 = 32'd2;
    tick();
    start = 1'b0;
    drain();
    tick();

    // MUL accepted on the DONE cycle of an ADD
    issue(OP_ADD, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1'b0);
    issue(OP_MUL, 32'h1234_5678, 32'h0000_0009, 32'hA3D7_0A38, 1'b0);
    drain();
    tick();

    // reset ten cycles into a divide aborts it, overriding a concurrent start
    issue(OP_DIV, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0);
    repeat (8) tick();
    reset = 1'b1; start = 1'b1; opcode = OP_ADD; alu0 = 32'd1; alu1 = 32'd1;
    q0.delete();
    q1.delete();
    for (int k = 0; k < 2; k++) begin
      last_res[k] = 32'd0;
      last_dz[k]  = 1'b0;
      bs[k] = 1;
      be[k] = 0;
    end
    tick();
    reset = 1'b0;
    start = 1'b0;
    repeat (40) tick();

    run(OP_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
